// File: rtl/uart_sha256_ctrl_v3.sv
// Host-protocol controller between the UART cores and the SHA-256 processor:
// length-prefixed frames in, status byte plus raw or ASCII-hex digest out.
module uart_sha256_ctrl_v3 #(
    parameter int LEN_BYTES      = 2,
    parameter int MAX_LEN        = 1024,
    parameter int TIMEOUT_CYCLES = 46875
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [7:0]   tx_data,
    output logic         tx_start,
    input  logic         tx_busy,
    output logic         proc_start,
    output logic [7:0]   proc_data,
    output logic         proc_valid,
    output logic         proc_last,
    output logic         proc_abort,
    input  logic [255:0] hash_in,
    input  logic         hash_done,
    output logic         busy
);
    localparam int LW  = 8 * LEN_BYTES;
    localparam int PCW = $clog2(MAX_LEN + 1);
    localparam int TOW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [7:0] STAT_OK   = 8'h00;
    localparam logic [7:0] STAT_ZERO = 8'hE1;
    localparam logic [7:0] STAT_LONG = 8'hE2;
    localparam logic [7:0] STAT_TMO  = 8'hE3;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_LEN         = 3'd1,
        S_PAYLOAD     = 3'd2,
        S_WAIT_DONE   = 3'd3,
        S_SEND_STATUS = 3'd4,
        S_SEND_HASH   = 3'd5,
        S_DRAIN       = 3'd6
    } state_t;

    state_t           state_r;
    logic             hex_mode_r;
    logic [LW-1:0]    len_r;
    logic [2:0]       len_cnt_r;
    logic [PCW-1:0]   pay_cnt_r;
    logic [TOW-1:0]   to_cnt_r;
    logic             started_r;
    logic [7:0]       status_r;
    logic [255:0]     hash_r;
    logic [5:0]       idx_r;
    logic             tx_prev_r;

    logic [LW-1:0]    len_next_s;
    logic             len_last_s;
    logic             pay_last_s;
    logic             tx_ok_s;
    logic             timeout_s;
    logic [7:0]       hash_byte_s;
    logic [7:0]       hex_char_s;

    function automatic logic [7:0] nib2hex(input logic [3:0] n);
        if (n < 4'd10) begin
            nib2hex = 8'h30 + {4'h0, n};
        end else begin
            nib2hex = 8'h57 + {4'h0, n};
        end
    endfunction

    // Next-state helpers: length shift, end-of-field/payload detect, tx guard, digest byte select
    always_comb begin
        len_next_s  = LW'({len_r, rx_data});
        len_last_s  = (len_cnt_r == 3'(LEN_BYTES - 1));
        pay_last_s  = ((32'(pay_cnt_r) + 32'd1) == 32'(len_r));
        // tx_busy rises one cycle late, so the two cycles after a start are also blocked
        tx_ok_s     = !tx_busy && !tx_start && !tx_prev_r;
        hash_byte_s = hash_r[{~idx_r[4:0], 3'b000} +: 8];
        hex_char_s  = nib2hex(hash_r[{~idx_r[5:0], 2'b00} +: 4]);
        if (TIMEOUT_CYCLES == 0) begin
            timeout_s = 1'b0;
        end else begin
            timeout_s = !rx_valid && (32'(to_cnt_r) == (32'(TIMEOUT_CYCLES) - 32'd1));
        end
    end

    // Protocol FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            hex_mode_r <= 1'b0;
            len_r      <= '0;
            len_cnt_r  <= 3'd0;
            pay_cnt_r  <= '0;
            to_cnt_r   <= '0;
            started_r  <= 1'b0;
            status_r   <= 8'h00;
            hash_r     <= 256'd0;
            idx_r      <= 6'd0;
            tx_prev_r  <= 1'b0;
            tx_data    <= 8'h00;
            tx_start   <= 1'b0;
            proc_start <= 1'b0;
            proc_data  <= 8'h00;
            proc_valid <= 1'b0;
            proc_last  <= 1'b0;
            proc_abort <= 1'b0;
            busy       <= 1'b0;
        end else begin
            tx_start   <= 1'b0;
            proc_start <= 1'b0;
            proc_valid <= 1'b0;
            proc_last  <= 1'b0;
            proc_abort <= 1'b0;
            tx_prev_r  <= tx_start;
            case (state_r)
                S_IDLE: begin
                    len_r     <= '0;
                    len_cnt_r <= 3'd0;
                    pay_cnt_r <= '0;
                    to_cnt_r  <= '0;
                    started_r <= 1'b0;
                    if (rx_valid && (rx_data == 8'h01 || rx_data == 8'h02)) begin
                        hex_mode_r <= (rx_data == 8'h02);
                        busy       <= 1'b1;
                        state_r    <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (rx_valid) begin
                        to_cnt_r  <= '0;
                        len_r     <= len_next_s;
                        len_cnt_r <= len_cnt_r + 3'd1;
                        if (len_last_s) begin
                            if (len_next_s == '0) begin
                                status_r <= STAT_ZERO;
                                state_r  <= S_SEND_STATUS;
                            end else if (32'(len_next_s) > 32'(MAX_LEN)) begin
                                status_r <= STAT_LONG;
                                state_r  <= S_SEND_STATUS;
                            end else begin
                                proc_start <= 1'b1;
                                started_r  <= 1'b1;
                                state_r    <= S_PAYLOAD;
                            end
                        end
                    end else if (timeout_s) begin
                        status_r <= STAT_TMO;
                        state_r  <= S_SEND_STATUS;
                    end else begin
                        to_cnt_r <= to_cnt_r + TOW'(1);
                    end
                end
                S_PAYLOAD: begin
                    if (rx_valid) begin
                        to_cnt_r   <= '0;
                        proc_data  <= rx_data;
                        proc_valid <= 1'b1;
                        pay_cnt_r  <= pay_cnt_r + PCW'(1);
                        if (pay_last_s) begin
                            proc_last <= 1'b1;
                            state_r   <= S_WAIT_DONE;
                        end
                    end else if (timeout_s) begin
                        proc_abort <= started_r;
                        status_r   <= STAT_TMO;
                        state_r    <= S_SEND_STATUS;
                    end else begin
                        to_cnt_r <= to_cnt_r + TOW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (hash_done) begin
                        hash_r   <= hash_in;
                        status_r <= STAT_OK;
                        state_r  <= S_SEND_STATUS;
                    end
                end
                S_SEND_STATUS: begin
                    if (tx_ok_s) begin
                        tx_data  <= status_r;
                        tx_start <= 1'b1;
                        idx_r    <= 6'd0;
                        state_r  <= (status_r == STAT_OK) ? S_SEND_HASH : S_DRAIN;
                    end
                end
                S_SEND_HASH: begin
                    if (tx_ok_s) begin
                        tx_data  <= hex_mode_r ? hex_char_s : hash_byte_s;
                        tx_start <= 1'b1;
                        idx_r    <= idx_r + 6'd1;
                        if (hex_mode_r ? (idx_r == 6'd63) : (idx_r == 6'd31)) begin
                            state_r <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (tx_ok_s) begin
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_sha256_ctrl_v3.sv
// Self-checking bench: random frames against a SHA-256 reference, a hash-core model
// and a lagging UART-tx model.
module tb_uart_sha256_ctrl_v3;
    localparam int LB  = 2;
    localparam int MAXL = 1024;
    localparam int TMO = 300;
    localparam int BOUND = 5000;

    typedef logic [7:0] bq_t [$];

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [31:0] H0 [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic [7:0]   tx_data;
    logic         tx_start;
    logic         tx_busy = 1'b0;
    logic         proc_start;
    logic [7:0]   proc_data;
    logic         proc_valid;
    logic         proc_last;
    logic         proc_abort;
    logic [255:0] hash_in = 256'd0;
    logic         hash_done = 1'b0;
    logic         busy;

    uart_sha256_ctrl_v3 #(.LEN_BYTES(LB), .MAX_LEN(MAXL), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .proc_start(proc_start), .proc_data(proc_data), .proc_valid(proc_valid),
        .proc_last(proc_last), .proc_abort(proc_abort),
        .hash_in(hash_in), .hash_done(hash_done), .busy(busy));

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha256_model(input bq_t msg);
        bq_t p;
        logic [31:0] h [0:7];
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        logic [63:0] bits;
        p = msg;
        bits = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        h = H0;
        for (int blk = 0; blk < p.size() / 64; blk++) begin
            for (int t = 0; t < 16; t++)
                w[t] = {p[blk*64+4*t], p[blk*64+4*t+1], p[blk*64+4*t+2], p[blk*64+4*t+3]};
            for (int t = 16; t < 64; t++) begin
                s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
                s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = w[t-16] + s0 + w[t-7] + s1;
            end
            a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
            for (int t = 0; t < 64; t++) begin
                t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
                t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
                hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
            end
            h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
        end
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    // Expected tx byte stream for one frame, straight from the framing rules
    function automatic bq_t expect_reply(input logic [7:0] cmd, input int len, input bq_t pl);
        bq_t r;
        logic [255:0] dg;
        string s;
        if (len == 0) r.push_back(8'hE1);
        else if (len > MAXL) r.push_back(8'hE2);
        else begin
            dg = sha256_model(pl);
            r.push_back(8'h00);
            if (cmd == 8'h02) begin
                s = $sformatf("%064h", dg);
                for (int i = 0; i < 64; i++) r.push_back(8'(s[i]));
            end else begin
                for (int i = 0; i < 32; i++) r.push_back(dg[255-8*i -: 8]);
            end
        end
        return r;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // UART tx model: busy rises one cycle after it sees tx_start, protocol violations counted
    bq_t  tx_q;
    int   since_tx = 100, busy_left = 0, tx_viol = 0, tx_cyc = 0;
    logic busy_pend = 1'b0;
    always @(negedge clk) begin
        if (tx_start) begin
            tx_q.push_back(tx_data);
            if (tx_busy || since_tx < 2) tx_viol <= tx_viol + 1;
            since_tx <= 0;
            tx_cyc <= cyc;
            busy_pend <= 1'b1;
        end else if (since_tx < 100) begin
            since_tx <= since_tx + 1;
        end
        if (busy_pend) begin
            tx_busy <= 1'b1; busy_left <= $urandom_range(3, 12); busy_pend <= 1'b0;
        end else if (busy_left > 1) begin
            busy_left <= busy_left - 1;
        end else begin
            tx_busy <= 1'b0; busy_left <= 0;
        end
    end

    // Hash-core model: gathers payload, returns its digest after a random delay
    bq_t pq;
    int  n_start = 0, n_valid = 0, n_last = 0, n_abort = 0, last_pos = -1, stray_last = 0;
    int  done_cnt = 0, abort_cyc = 0;
    always @(negedge clk) begin
        hash_done <= 1'b0;
        if (done_cnt != 0) done_cnt <= done_cnt - 1;
        if (done_cnt == 1) begin hash_in <= sha256_model(pq); hash_done <= 1'b1; end
        if (proc_start) begin pq.delete(); n_start <= n_start + 1; end
        if (proc_valid) begin
            pq.push_back(proc_data);
            n_valid <= n_valid + 1;
            if (proc_last) begin
                n_last <= n_last + 1; last_pos <= pq.size() - 1; done_cnt <= $urandom_range(5, 20);
            end
        end else if (proc_last) begin
            stray_last <= stray_last + 1;
        end
        if (proc_abort) begin pq.delete(); n_abort <= n_abort + 1; abort_cyc <= cyc; done_cnt <= 0; end
    end

    int errors = 0, checks = 0, last_rx_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk); rx_data = b; rx_valid = 1'b1;
        @(negedge clk); rx_valid = 1'b0; last_rx_cyc = cyc;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk({tag, " idle_bound"}, 64'(busy), 64'd0);
    endtask

    task automatic run_frame(input logic [7:0] cmd, input int len, input bq_t pl, input int max_gap,
                             input bit stray, input string tag, output int base);
        bq_t exp;
        int vb, sb, lb, nbad;
        bit acc;
        base = tx_q.size(); vb = n_valid; sb = n_start; lb = n_last;
        acc = (len >= 1) && (len <= MAXL);
        send_byte(cmd, $urandom_range(0, max_gap));
        for (int i = LB - 1; i >= 0; i--) send_byte(8'(len >> (8*i)), $urandom_range(0, max_gap));
        if (acc) foreach (pl[i]) send_byte(pl[i], $urandom_range(0, max_gap));
        if (stray) send_byte(8'h01, 0);
        wait_idle(tag);
        exp = expect_reply(cmd, len, pl);
        chk({tag, " tx_count"}, 64'(tx_q.size() - base), 64'(exp.size()));
        nbad = 0;
        foreach (exp[i]) if (base + i >= tx_q.size() || tx_q[base+i] !== exp[i]) nbad++;
        chk({tag, " tx_bytes_bad"}, 64'(nbad), 64'd0);
        chk({tag, " proc_start_count"}, 64'(n_start - sb), acc ? 64'd1 : 64'd0);
        chk({tag, " proc_valid_count"}, 64'(n_valid - vb), acc ? 64'(len) : 64'd0);
        if (acc) begin
            nbad = 0;
            foreach (pl[i]) if (i >= pq.size() || pq[i] !== pl[i]) nbad++;
            chk({tag, " proc_data_bad"}, 64'(nbad), 64'd0);
            chk({tag, " proc_last_pos"}, 64'(last_pos), 64'(len - 1));
            chk({tag, " proc_last_count"}, 64'(n_last - lb), 64'd1);
        end
        chk({tag, " tx_guard_viol"}, 64'(tx_viol), 64'd0);
        chk({tag, " stray_last"}, 64'(stray_last), 64'd0);
    endtask

    task automatic timeout_frame(input bq_t bytes, input bit exp_abort, input string tag);
        int base, ab;
        base = tx_q.size(); ab = n_abort;
        foreach (bytes[i]) send_byte(bytes[i], 1);
        wait_idle(tag);
        chk({tag, " tx_count"}, 64'(tx_q.size() - base), 64'd1);
        chk({tag, " tx_status"}, (tx_q.size() > base) ? 64'(tx_q[base]) : 64'hx, 64'hE3);
        chk({tag, " abort_count"}, 64'(n_abort - ab), exp_abort ? 64'd1 : 64'd0);
        chk({tag, " status_delay"}, 64'(tx_cyc - last_rx_cyc), 64'(TMO + 1));
        if (exp_abort) chk({tag, " abort_delay"}, 64'(abort_cyc - last_rx_cyc), 64'(TMO));
    endtask

    initial begin
        bq_t abc, pl, tb;
        int base, len, got;
        logic [7:0] cmd;
        abc = '{8'h61, 8'h62, 8'h63};

        repeat (3) @(negedge clk);
        chk("rst tx_start", 64'(tx_start), 64'd0);
        chk("rst tx_data", 64'(tx_data), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst proc_ctl", 64'({proc_start, proc_valid, proc_last, proc_abort}), 64'd0);
        chk("rst proc_data", 64'(proc_data), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        chk("model abc hi", sha256_model(abc) >> 128, 128'hba7816bf8f01cfea414140de5dae2223);
        chk("model abc lo", 64'(sha256_model(abc)), 64'hb410ff61f20015ad);

        run_frame(8'h01, 3, abc, 3, 1'b0, "t1 raw abc", base);
        chk("t1 first digest byte", 64'(tx_q[base+1]), 64'hBA);
        chk("t1 last digest byte", 64'(tx_q[base+32]), 64'hAD);

        run_frame(8'h02, 3, abc, 3, 1'b0, "t2 hex abc", base);
        chk("t2 first char", 64'(tx_q[base+1]), 64'h62);
        chk("t2 second char", 64'(tx_q[base+2]), 64'h61);

        pl = '{8'hFF, 8'hFF};
        run_frame(8'h01, 2, pl, 2, 1'b1, "t3 ff ff", base);

        pl = {};
        run_frame(8'h01, 0, pl, 2, 1'b0, "t4 len0", base);
        chk("t4 len0 busy", 64'(busy), 64'd0);
        run_frame(8'h01, 1025, pl, 2, 1'b0, "t4 len1025", base);
        chk("t4 len1025 busy", 64'(busy), 64'd0);
        for (int i = 0; i < MAXL; i++) pl.push_back(8'($urandom));
        run_frame(8'h01, MAXL, pl, 0, 1'b0, "t4 len max", base);
        pl = '{8'h00};
        run_frame(8'h02, 1, pl, 1, 1'b0, "t4 len1 hex", base);

        tb = '{8'h01, 8'h00, 8'h05, 8'hAA, 8'hBB};
        timeout_frame(tb, 1'b1, "t5 payload timeout");
        run_frame(8'h01, 3, abc, 3, 1'b0, "t5 after timeout", base);
        tb = '{8'h02, 8'h00};
        timeout_frame(tb, 1'b0, "t5 len timeout");

        send_byte(8'h55, 1);
        send_byte(8'h00, 1);
        run_frame(8'h02, 3, abc, 2, 1'b0, "ignored idle bytes", base);

        for (int f = 0; f < 10; f++) begin
            len = $urandom_range(1, 100);
            cmd = ($urandom_range(0, 1) == 1) ? 8'h02 : 8'h01;
            pl = {};
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
            run_frame(cmd, len, pl, 4, 1'b0, $sformatf("rand%0d", f), base);
        end

        base = tx_q.size();
        send_byte(8'h01, 1); send_byte(8'h00, 1); send_byte(8'h03, 1);
        foreach (abc[i]) send_byte(abc[i], 1);
        got = 0;
        for (int i = 0; i < BOUND; i++) begin
            @(posedge clk); #1;
            if (tx_q.size() >= base + 11) begin got = 1; break; end
        end
        chk("t6 reached hash byte 10", 64'(got), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6 tx_start in reset", 64'(tx_start), 64'd0);
        chk("t6 busy in reset", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(8'h01, 3, abc, 3, 1'b0, "t6 post reset", base);
        chk("t6 post reset digest byte", 64'(tx_q[base+1]), 64'hBA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
